// File: rtl/inst_cache_line.sv
// Direct-mapped instruction cache with zero-latency hits and a word-by-word line refill
// from the memory controller. There is no critical-word forwarding during the refill.
module inst_cache_line #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int ADDR_BITS   = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        IF_able_read,
    input  logic [31:0] IF_inst_addr,
    output logic        IF_inst_valid,
    output logic [31:0] IF_inst,
    input  logic        MC_inst_valid,
    input  logic [31:0] MC_inst,
    output logic        MC_able_read,
    output logic [31:0] MC_inst_addr
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int BASE_LO  = OFFSET_BITS + 2;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                   r_state;
    logic [OFFSET_BITS-1:0]   r_cnt;
    logic [31-BASE_LO:0]      r_base;
    logic [LINES-1:0]         r_valid;
    logic [TAG_BITS-1:0]      r_tag  [LINES];
    logic [31:0]              r_data [LINES*WORDS];

    logic [INDEX_BITS-1:0]    w_idx;
    logic [OFFSET_BITS-1:0]   w_off;
    logic [TAG_BITS-1:0]      w_tag;
    logic [INDEX_BITS-1:0]    w_fill_idx;
    logic [TAG_BITS-1:0]      w_fill_tag;
    logic                     w_active;
    logic                     w_hit;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_refill_out;
    logic [1:0]               w_unused;

    assign w_idx      = IF_inst_addr[BASE_LO+INDEX_BITS-1:BASE_LO];
    assign w_off      = IF_inst_addr[BASE_LO-1:2];
    assign w_tag      = IF_inst_addr[ADDR_BITS-1:BASE_LO+INDEX_BITS];
    assign w_fill_idx = r_base[INDEX_BITS-1:0];
    assign w_fill_tag = r_base[ADDR_BITS-BASE_LO-1:INDEX_BITS];
    assign w_unused   = IF_inst_addr[1:0];

    // rst and a low rdy both silence every output, including a hit
    assign w_active = !rst && rdy;
    assign w_hit    = w_active && (r_state == IDLE) && IF_able_read && !flush &&
                      r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept = w_active && !flush && (r_state == REFILL) && MC_inst_valid;
    assign w_last   = (r_cnt == {OFFSET_BITS{1'b1}});

    assign IF_inst_valid = w_hit;
    assign IF_inst       = w_hit ? r_data[{w_idx, w_off}] : 32'h0;

    assign w_refill_out  = w_active && (r_state == REFILL);
    assign MC_able_read  = w_refill_out;
    // Base has its offset bits cleared, so concatenating the counter cannot carry into the tag
    assign MC_inst_addr  = w_refill_out ? {r_base, r_cnt, 2'b00} : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_valid <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_valid <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (IF_able_read && !w_hit) begin
                            r_base         <= IF_inst_addr[31:BASE_LO];
                            r_cnt          <= '0;
                            r_valid[w_idx] <= 1'b0;
                            r_state        <= REFILL;
                        end
                    end
                    REFILL: begin
                        if (MC_inst_valid) begin
                            r_cnt <= r_cnt + OFFSET_BITS'(1);
                            if (w_last) begin
                                r_valid[w_fill_idx] <= 1'b1;
                                r_state             <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Storage arrays carry no reset; r_valid alone decides whether their contents are used
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[{w_fill_idx, r_cnt}] <= MC_inst;
            if (w_last) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_inst_cache_line.sv
// Testbench for inst_cache_line. A line-presence model and a fixed memory image
// predict hits, misses, refill request order and the returned instruction words.
module tb_inst_cache_line;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, IF_able_read, MC_inst_valid;
    logic [31:0] IF_inst_addr, MC_inst;
    logic        IF_inst_valid, MC_able_read;
    logic [31:0] IF_inst, MC_inst_addr;

    int n_cmp = 0;
    int n_bad = 0;

    bit         m_valid [64];
    logic [7:0] m_tag   [64];

    always #5 clk = ~clk;

    inst_cache_line dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .IF_able_read  (IF_able_read),
        .IF_inst_addr  (IF_inst_addr),
        .IF_inst_valid (IF_inst_valid),
        .IF_inst       (IF_inst),
        .MC_inst_valid (MC_inst_valid),
        .MC_inst       (MC_inst),
        .MC_able_read  (MC_able_read),
        .MC_inst_addr  (MC_inst_addr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // Memory side: optional wait cycles, then return the word; the request is checked every cycle
    task automatic serve_word(input logic [31:0] waddr, input int maxwait);
        int w;
        w = $urandom_range(maxwait, 0);
        for (int i = 0; i <= w; i++) begin
            MC_inst_valid = (i == w);
            MC_inst       = (i == w) ? mem_word(waddr) : $urandom;
            #2;
            n_cmp++;
            if (MC_able_read !== 1'b1 || MC_inst_addr !== waddr || IF_inst_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mc_req: able=%0b addr=%h ifv=%0b, required able=1 addr=%h ifv=0",
                         MC_able_read, MC_inst_addr, IF_inst_valid, waddr);
            end
            step();
        end
        MC_inst_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        logic [5:0]  idx;
        logic [7:0]  tag;
        logic [31:0] base;
        idx  = a[9:4];
        tag  = a[17:10];
        base = {a[31:4], 4'h0};
        IF_able_read = 1'b1;
        IF_inst_addr = a;
        #2;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            n_cmp++;
            if (IF_inst_valid !== 1'b1 || IF_inst !== mem_word(a) || MC_able_read !== 1'b0) begin
                n_bad++;
                $display("FAIL hit %h: ifv=%0b inst=%h mcr=%0b, required 1 %h 0",
                         a, IF_inst_valid, IF_inst, MC_able_read, mem_word(a));
            end
            step();
        end else begin
            n_cmp++;
            if (IF_inst_valid !== 1'b0 || IF_inst !== 32'h0 || MC_able_read !== 1'b0) begin
                n_bad++;
                $display("FAIL miss %h: ifv=%0b inst=%h mcr=%0b, required 0 0 0",
                         a, IF_inst_valid, IF_inst, MC_able_read);
            end
            m_valid[idx] = 1'b0;
            step();
            for (int k = 0; k < 4; k++) serve_word(base + 32'(4 * k), 2);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            #2;
            n_cmp++;
            if (IF_inst_valid !== 1'b1 || IF_inst !== mem_word(a) || MC_able_read !== 1'b0 ||
                MC_inst_addr !== 32'h0) begin
                n_bad++;
                $display("FAIL post_fill_hit %h: ifv=%0b inst=%h mcr=%0b mca=%h, required 1 %h 0 0",
                         a, IF_inst_valid, IF_inst, MC_able_read, MC_inst_addr, mem_word(a));
            end
            step();
        end
    endtask

    task automatic check_quiet(input string name);
        #2;
        n_cmp++;
        if (IF_inst_valid !== 1'b0 || IF_inst !== 32'h0 || MC_able_read !== 1'b0 ||
            MC_inst_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL %s: ifv=%0b inst=%h mcr=%0b mca=%h, required all 0",
                     name, IF_inst_valid, IF_inst, MC_able_read, MC_inst_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        IF_able_read = 1'b1; IF_inst_addr = 32'h104;
        MC_inst_valid = 1'b1; MC_inst = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_quiet("reset_outputs");
            step();
        end
        rst = 1'b0; MC_inst_valid = 1'b0; IF_able_read = 1'b0;
        clear_model();
    endtask

    task automatic test_basic();
        do_fetch(32'h0000_0104);
        do_fetch(32'h0000_010C);
    endtask

    task automatic test_conflict();
        do_fetch(32'h0000_1104);
        do_fetch(32'h0000_0104);
    endtask

    task automatic test_stray_mc();
        IF_able_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MC_inst_valid = 1'b1; MC_inst = $urandom;
            check_quiet("stray_mc");
            step();
        end
        MC_inst_valid = 1'b0;
        do_fetch(32'h0000_010C);
    endtask

    task automatic test_flush();
        IF_able_read = 1'b1; IF_inst_addr = 32'h104; flush = 1'b1;
        check_quiet("flush_idle");
        step();
        flush = 1'b0;
        clear_model();
        IF_inst_addr = 32'h100;
        check_quiet("flush_refetch_miss");
        step();
        serve_word(32'h100, 1);
        serve_word(32'h104, 1);
        flush = 1'b1; MC_inst_valid = 1'b1; MC_inst = 32'h1234_5678;
        #2;
        n_cmp++;
        if (IF_inst_valid !== 1'b0 || IF_inst !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_refill_cycle: ifv=%0b inst=%h, required 0 0", IF_inst_valid, IF_inst);
        end
        step();
        flush = 1'b0; MC_inst_valid = 1'b0; IF_able_read = 1'b0;
        check_quiet("flush_back_idle");
        step();
        do_fetch(32'h100);
    endtask

    task automatic test_rdy_stall();
        IF_able_read = 1'b1; IF_inst_addr = 32'h200;
        check_quiet("stall_miss");
        step();
        serve_word(32'h200, 0);
        serve_word(32'h204, 0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MC_inst_valid = 1'b1; MC_inst = $urandom;
            check_quiet("rdy_low");
            step();
        end
        rdy = 1'b1; MC_inst_valid = 1'b0;
        serve_word(32'h208, 1);
        serve_word(32'h20C, 1);
        m_valid[6'h20] = 1'b1;
        m_tag[6'h20]   = 8'h00;
        #2;
        n_cmp++;
        if (IF_inst_valid !== 1'b1 || IF_inst !== mem_word(32'h200)) begin
            n_bad++;
            $display("FAIL stall_hit: ifv=%0b inst=%h, required 1 %h",
                     IF_inst_valid, IF_inst, mem_word(32'h200));
        end
        step();
    endtask

    task automatic test_addr_change();
        flush = 1'b1; IF_able_read = 1'b0;
        step();
        flush = 1'b0;
        clear_model();
        IF_able_read = 1'b1; IF_inst_addr = 32'h100;
        check_quiet("change_miss");
        step();
        serve_word(32'h100, 1);
        IF_inst_addr = 32'h200;
        serve_word(32'h104, 1);
        IF_able_read = 1'b0;
        serve_word(32'h108, 1);
        IF_able_read = 1'b1;
        serve_word(32'h10C, 1);
        m_valid[6'h10] = 1'b1;
        m_tag[6'h10]   = 8'h00;
        do_fetch(32'h200);
        do_fetch(32'h100);
    endtask

    task automatic test_mid_reset();
        IF_able_read = 1'b1; IF_inst_addr = 32'h3F0;
        check_quiet("midrst_miss");
        step();
        serve_word(32'h3F0, 0);
        serve_word(32'h3F4, 0);
        rst = 1'b1; flush = 1'b1; MC_inst_valid = 1'b1; MC_inst = 32'hAAAA_5555;
        check_quiet("midrst_outputs");
        step();
        rst = 1'b0; flush = 1'b0; MC_inst_valid = 1'b0;
        clear_model();
        do_fetch(32'h3F8);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  tg;
        logic [5:0]  ix;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                IF_able_read = 1'b0;
                MC_inst_valid = 1'($urandom); MC_inst = $urandom;
                check_quiet("rand_idle");
                step();
                MC_inst_valid = 1'b0;
            end else begin
                tg = ($urandom_range(1, 0) == 1) ? 8'h05 : 8'h00;
                case ($urandom_range(2, 0))
                    0:       ix = 6'h01;
                    1:       ix = 6'h02;
                    default: ix = 6'h21;
                endcase
                a = {14'h0, tg, ix, 2'($urandom), 2'b00};
                do_fetch(a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_stray_mc();
        test_flush();
        test_rdy_stall();
        test_addr_change();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
